byte_pair_assembler: RTL and testbench
======================================

# byte_pair_assembler

Upstream feeder for the packed-pair datapath. Accepts a valid/ready byte stream, groups consecutive bytes into 16-bit pairs (first byte high, second byte low) and presents each pair on a registered valid/ready output. The output carries the pair and its low byte separately, so it drives the pair-operations stage's 16-bit packed input and 8-bit byte input directly. Odd-length frames are padded, and the padded pair is flagged.

## Interface
- `PAD_BYTE`, default 8'h00: low byte inserted when a frame ends on a high byte.
- `CNT_W`, default 8: width of `pair_count`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  `in_byte` / `in_last` are valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `in_byte`  in  8  stream byte.
- `in_last`  in  1  final byte of the frame.
- `out_valid`  out  1  pair registers hold a complete pair.
- `out_ready`  in  1  downstream accepts the pair.
- `out_pair`  out  16  [15:8] = first byte, [7:0] = second byte or `PAD_BYTE`.
- `out_byte`  out  8  copy of `out_pair[7:0]`.
- `out_last`  out  1  this pair ends the frame.
- `out_odd`  out  1  low byte is padding.
- `pair_count`  out  CNT_W  index of the presented pair within the current frame.

## Operation
- Handshakes: a byte is accepted when `in_valid && in_ready`. A pair is consumed when `out_valid && out_ready`.
- FSM states:
  - EMPTY: no partial pair, output empty.
  - HALF: high byte held in `hold_hi`, output empty.
  - FULL: pair presented; no pending high byte.
- `in_ready`:
  - 1 in EMPTY and HALF.
  - In FULL, equals `out_ready`.
  - Forced 0 while `rst_n` is low.
- Transitions on an accepted byte:
  - EMPTY, `in_last`=0 → HALF; `hold_hi` ← byte.
  - EMPTY, `in_last`=1 → FULL; pair = {byte, `PAD_BYTE`}; `out_odd`=1; `out_last`=1.
  - HALF, any → FULL; pair = {`hold_hi`, byte}; `out_odd`=0; `out_last`=`in_last`.
  - FULL with simultaneous consume: the byte is treated exactly as from EMPTY (→ HALF, or → FULL with a new padded pair).
- FULL with consume and no byte → EMPTY.
- `in_last` on the second byte of a pair is never padded.
- `pair_count`:
  - Increments on each consume.
  - Wraps modulo 2^CNT_W.
  - Returns to 0 on consume of a pair with `out_last`=1.
- `out_byte` always equals `out_pair[7:0]`; it is not separately registered.

## Timing
- All outputs are registered except `in_ready`, which is a combinational function of state and `out_ready`.
- Reset values: state EMPTY, `out_valid`=0, `out_pair`=16'h0000, `out_byte`=8'h00, `out_last`=0, `out_odd`=0, `pair_count`=0, `hold_hi`=8'h00.
- Latency: completing byte accepted at edge N → `out_valid`=1 in the cycle after edge N.
- With `out_ready` held high, sustained throughput is one pair per two input bytes, with no bubbles.
- While `out_valid`=1 and `out_ready`=0, `out_pair`, `out_byte`, `out_last`, `out_odd` and `pair_count` stay stable.
- `out_valid` is never withdrawn before it is consumed.
- Reset asserted mid-frame discards the partial pair and any presented pair immediately. The first byte after reset is a high byte.

## Structure
- Shared package `pair_pkg`:
  - `pair_t`: packed struct, `high` declared first ([15:8]), then `low` ([7:0]).
  - `asm_state_t` enum: EMPTY, HALF, FULL.
  - Default `PAD_BYTE` constant.
- The pair-operations stage uses the same `pair_t`.
- No sub-module: the FSM, hold register and counter stay in one module.

## Test plan
- Reset, then with `out_ready`=1 send 8'hA1, 8'hB2 (last). Expect one pair 16'hA1B2, `out_byte`=8'hB2, `out_last`=1, `out_odd`=0, `pair_count`=0.
- Send 8'h11, 8'h22, 8'h33 (last). Expect 16'h1122 (count 0, `out_last`=0), then 16'h3300 (count 1, `out_last`=1, `out_odd`=1). After the final consume, count reads 0.
- Backpressure: `out_ready`=0 with a pair presented and 8'h44 offered. Expect `in_ready`=0 and the outputs stable for 5 cycles. Raise `out_ready`: pair consumed and 8'h44 accepted on the same edge → HALF.
- Back-to-back frame of 6 bytes 01..06 with `out_ready`=1. Expect pairs 0102, 0304, 0506 on consecutive output beats every 2 cycles, with no dropped or duplicated bytes.
- Assert `rst_n` low in HALF after 8'h77, then release and send 8'h88, 8'h99 (last). Expect pair 16'h8899; 8'h77 is lost. All outputs read their reset values during reset.
- With `CNT_W`=2, send a 10-pair frame. Expect `pair_count` sequence 0,1,2,3,0,1,2,3,0,1.

Source files
------------

// File: rtl/pair_pkg.sv
// Shared types for the byte-pair assembler and the pair-operations stage.
// pair_t keeps the first stream byte in the high half.
package pair_pkg;

  typedef struct packed {
    logic [7:0] high;
    logic [7:0] low;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } asm_state_t;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;

endpackage

// File: rtl/byte_pair_assembler.sv
// Groups a valid/ready byte stream into 16-bit pairs (first byte high) and
// presents them on a registered valid/ready output; odd frames get a padded pair.
module byte_pair_assembler
  import pair_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pair,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             out_odd,
  output logic [CNT_W-1:0] pair_count
);

  asm_state_t       state, state_n, base;
  logic [7:0]       hold_hi, hold_n;
  pair_t            pair_q, pair_n;
  logic             valid_q, valid_n;
  logic             last_q, last_n;
  logic             odd_q, odd_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             accept, consume;

  // FULL only takes a byte when the presented pair leaves on the same edge.
  assign in_ready = rst_n && ((state != FULL) || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_comb begin
    state_n = state;
    hold_n  = hold_hi;
    pair_n  = pair_q;
    last_n  = last_q;
    odd_n   = odd_q;
    cnt_n   = cnt_q;
    // A consumed FULL slot behaves as EMPTY for the byte arriving this edge.
    base    = (state == FULL && consume) ? EMPTY : state;
    state_n = base;

    if (consume)
      cnt_n = last_q ? '0 : cnt_q + 1'b1;

    case (base)
      EMPTY: begin
        if (accept) begin
          if (in_last) begin
            state_n = FULL;
            pair_n  = '{high: in_byte, low: PAD_BYTE};
            odd_n   = 1'b1;
            last_n  = 1'b1;
          end else begin
            state_n = HALF;
            hold_n  = in_byte;
          end
        end
      end
      HALF: begin
        if (accept) begin
          state_n = FULL;
          pair_n  = '{high: hold_hi, low: in_byte};
          odd_n   = 1'b0;
          last_n  = in_last;
        end
      end
      default: ;
    endcase

    valid_n = (state_n == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      hold_hi <= 8'h00;
      pair_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      odd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      hold_hi <= hold_n;
      pair_q  <= pair_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      odd_q   <= odd_n;
      cnt_q   <= cnt_n;
    end
  end

  assign out_valid  = valid_q;
  assign out_pair   = pair_q;
  assign out_byte   = pair_q.low;
  assign out_last   = last_q;
  assign out_odd    = odd_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_byte_pair_assembler.sv
// Scoreboard bench for byte_pair_assembler: frames are turned into expected
// pairs up front, a monitor pops and compares on every output handshake.
module tb_byte_pair_assembler;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_byte = 8'h00;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_pair;
  logic [7:0]       out_byte;
  logic             out_last;
  logic             out_odd;
  logic [CNT_W-1:0] pair_count;

  byte_pair_assembler #(.PAD_BYTE(8'h00), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair),
    .out_byte(out_byte), .out_last(out_last), .out_odd(out_odd),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      pair;
    logic             last;
    logic             odd;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  int         cons_t[$];
  int         checks = 0, errors = 0, cyc = 0, rdy_mode = 1;
  bit         log_cons = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: samples mid-cycle once the ready driver has settled.
  logic             prev_hold = 1'b0;
  logic [15:0]      s_pair;
  logic             s_last, s_odd;
  logic [CNT_W-1:0] s_cnt;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("valid_held", 32'(out_valid), 32'd1);
        chk("stable_pair", 32'(out_pair), 32'(s_pair));
        chk("stable_flags", {29'd0, out_last, out_odd, 1'b0}, {29'd0, s_last, s_odd, 1'b0});
        chk("stable_count", 32'(pair_count), 32'(s_cnt));
      end
      if (out_valid) chk("out_byte_copy", 32'(out_byte), 32'(out_pair[7:0]));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("pair", 32'(out_pair), 32'(e.pair));
          chk("last", 32'(out_last), 32'(e.last));
          chk("odd", 32'(out_odd), 32'(e.odd));
          chk("count", 32'(pair_count), 32'(e.cnt));
        end
        if (log_cons) cons_t.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      s_pair = out_pair; s_last = out_last; s_odd = out_odd; s_cnt = pair_count;
    end
  end

  // Reference: split the frame into pairs, pad an odd tail, index within frame.
  task automatic push_expected();
    for (int i = 0; i < fq.size(); i += 2) begin
      exp_t e;
      e.pair = {fq[i], (i + 1 < fq.size()) ? fq[i+1] : 8'h00};
      e.odd  = (i + 1 >= fq.size());
      e.last = (i + 2 >= fq.size());
      e.cnt  = CNT_W'((i / 2) % (1 << CNT_W));
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit acc, done;
    done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_last = last;
    for (int k = 0; k < 300; k++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) begin done = 1; break; end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int max_gap);
    push_expected();
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i], i == fq.size() - 1);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && !out_valid) break;
    end
    if (k == 500) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pair"}, 32'(out_pair), 32'd0);
    chk({tag, "_byte"}, 32'(out_byte), 32'd0);
    chk({tag, "_flags"}, {30'd0, out_last, out_odd}, 32'd0);
    chk({tag, "_count"}, 32'(pair_count), 32'd0);
  endtask

  initial begin
    logic [15:0] snap;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Two-byte frame, then a padded three-byte frame.
    rdy_mode = 1;
    fq = {8'hA1, 8'hB2}; send_frame(0); drain();
    fq = {8'h11, 8'h22, 8'h33}; send_frame(0); drain();
    chk("count_after_last", 32'(pair_count), 32'd0);

    // Backpressure: pair held, next byte blocked, then both move on one edge.
    rdy_mode = 2;
    fq = {8'h55, 8'h66}; send_frame(0);
    fq = {8'h44, 8'h45}; push_expected();
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'h44; in_last = 1'b0;
    #3 snap = out_pair;
    chk("bp_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk); #3;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_pair", 32'(out_pair), 32'(snap));
    end
    rdy_mode = 1;
    @(negedge clk); #3;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); #3;
    chk("bp_half_empty_out", 32'(out_valid), 32'd0);
    send_byte(8'h45, 1'b1);
    drain();

    // Back-to-back six bytes: one pair every two cycles.
    cons_t.delete(); log_cons = 1;
    fq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_frame(0); drain();
    log_cons = 0;
    chk("tput_beats", 32'(cons_t.size()), 32'd3);
    for (int i = 1; i < cons_t.size(); i++)
      chk("tput_spacing", 32'(cons_t[i] - cons_t[i-1]), 32'd2);

    // Reset in HALF loses the held byte.
    send_byte(8'h77, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    #2 chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fq = {8'h88, 8'h99}; send_frame(0); drain();

    // Ten-pair frame exercises counter wrap at CNT_W=2.
    rdy_mode = 0;
    fq.delete();
    for (int i = 0; i < 20; i++) fq.push_back(8'($urandom));
    send_frame(1); drain();

    // Random frames, random gaps and backpressure.
    for (int f = 0; f < 15; f++) begin
      int len;
      len = $urandom_range(1, 9);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
      send_frame(2);
    end
    drain();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
